ipml_prefetch_fifo_v2_0_sync: RTL and testbench
===============================================

// Module: ipml_prefetch_fifo_v2_0_sync
// PURPOSE
//   Single-clock first-word-fall-through FIFO with valid/ready handshakes on both sides.
//   It is built from an inferred 1-cycle-latency RAM and a prefetch output buffer whose
//   depth is set by parameter, and it adds an optional empty-bypass path, occupancy count,
//   almost-full/almost-empty thresholds, flush, and overflow/underflow pulses.
//   Intended as the general-purpose data buffer between single-clock-domain pipeline stages.
// PARAMETERS
//   c_DEPTH_WIDTH     10  RAM address width; RAM holds 2**c_DEPTH_WIDTH words (legal 4..20)
//   c_DATA_WIDTH      32  data width (legal 1..1152)
//   c_PREFETCH_DEPTH  2   output buffer entries (legal 2..4)
//   c_AF_LEVEL        2**c_DEPTH_WIDTH-4  almost_full when data_cnt >= c_AF_LEVEL
//   c_AE_LEVEL        4   almost_empty when data_cnt <= c_AE_LEVEL
//   c_BYPASS          0   1: a push into a totally empty FIFO goes straight to the output buffer
// PORTS
//   clk           in   1     clock; every register is on the rising edge
//   rst           in   1     synchronous reset, active-high
//   flush         in   1     synchronous clear of all contents, active-high
//   wr_data       in   DW    write data
//   wr_en         in   1     write request
//   wr_vld        out  1     write ready; push = wr_en & wr_vld
//   wr_ovf        out  1     1-cycle pulse: wr_en while wr_vld=0
//   rd_data       out  DW    head word; valid when rd_vld=1
//   rd_en         in   1     read ready; pop = rd_vld & rd_en
//   rd_vld        out  1     head word valid
//   rd_udf        out  1     1-cycle pulse: rd_en while rd_vld=0
//   data_cnt      out  AW+2  total words held (RAM + RAM read in flight + buffer)
//   almost_full   out  1     data_cnt >= c_AF_LEVEL
//   almost_empty  out  1     data_cnt <= c_AE_LEVEL
// BEHAVIOUR
//   - Reset, while rst=1: rd_vld=0, rd_data=0, wr_ovf=0, rd_udf=0, data_cnt=0,
//     almost_empty=1, almost_full=0, wr_vld=0.
//     From the first cycle after rst falls: wr_vld=1.
//     rst has priority over flush, push and pop.
//   - flush=1: same register effect as rst, except wr_vld stays 1. A push or pop in the
//     flush cycle is discarded and not counted; wr_ovf and rd_udf stay 0 in that cycle.
//   - RAM pointers: wr_ptr and rd_ptr are AW+1 bits; the MSB is the wrap bit.
//     ram_full when the pointers differ only in the MSB; ram_empty when they are equal.
//     wr_vld = ~ram_full, from registered state only.
//     A pop in the same cycle as full does not free a slot until the next cycle.
//   - Prefetch: a RAM read is issued when ~ram_empty and
//     (buf_cnt + inflight - pop) < c_PREFETCH_DEPTH.
//     At most 1 read is issued per cycle. Read data lands in the buffer 1 cycle later.
//     Word order is always preserved.
//   - Latency, c_BYPASS=0: a word pushed at edge E into an empty FIFO drives rd_vld/rd_data
//     after edge E+2.
//   - Latency, c_BYPASS=1: when RAM, in-flight and buffer are all empty, the push is written
//     into the buffer directly and appears after edge E+1. The RAM is not written.
//   - Buffer: the head is registered and drives rd_data. On pop the next entry shifts to
//     the head in the same edge, so back-to-back pops give 1 word/cycle while data is held.
//     rd_data holds its value while rd_vld=1 and rd_en=0.
//   - data_cnt: +1 on push, -1 on pop, unchanged on push+pop. It is registered and its
//     maximum is 2**AW + c_PREFETCH_DEPTH. The flags are registered and derived from the
//     next-state count, so they are in step with data_cnt.
//   - Pointers wrap modulo 2**(AW+1). There are no illegal states.
// TESTING
//   1. AW=4, PF=2, BYP=0: push 0xA5 at cycle 10 -> rd_vld=1, rd_data=0xA5 from cycle 12;
//      data_cnt=1.
//   2. Same push with BYP=1 -> rd_vld=1 from cycle 11; RAM write enable never asserted.
//   3. AW=4, PF=2, rd_en=0: push 18 words (0..17) -> wr_vld=0 after the 18th push,
//      data_cnt=18; a 19th wr_en gives wr_ovf=1 for one cycle and data_cnt stays 18.
//   4. Full FIFO with rd_en=1 constantly -> 18 pops on consecutive cycles, values 0..17,
//      no gaps; then rd_vld=0. One more rd_en gives rd_udf=1 for one cycle.
//   5. Random push/pop at 50% each, 10k cycles, AW=4, PF in {2,3,4}, AF=12, AE=3
//      -> scoreboard order exact; data_cnt equals the model each cycle; flags match the
//      thresholds; pointer wrap crossed at least 100 times.
//   6. flush with 7 words held, with push and pop asserted in the same cycle ->
//      next cycle data_cnt=0, rd_vld=0, almost_empty=1, wr_vld=1; rst mid-stream gives the
//      same result but wr_vld=0 during rst.

Source files
------------

// File: rtl/ipml_prefetch_fifo_v2_0_sync.sv
// ============================================================================
// ipml_prefetch_fifo_v2_0_sync
// ----------------------------------------------------------------------------
// Single-clock first-word-fall-through FIFO with valid/ready handshakes on both
// sides. Storage is an inferred RAM with a registered (1-cycle) read, followed
// by a small prefetch buffer of c_PREFETCH_DEPTH registered entries. The head
// of that buffer drives rd_data directly, so pops run at one word per cycle.
//
// Optional empty-bypass (c_BYPASS=1): a push into a completely empty FIFO skips
// the RAM and is loaded straight into the landing stage. It then reaches the
// head one edge after the push instead of two.
//
// Ports
//   clk           in   1      clock, rising edge
//   rst           in   1      synchronous reset, active-high
//   flush         in   1      synchronous clear of all contents, active-high
//   wr_data       in   DW     write data
//   wr_en         in   1      write request
//   wr_vld        out  1      write ready; push = wr_en & wr_vld
//   wr_ovf        out  1      pulse: wr_en seen while wr_vld=0
//   rd_data       out  DW     head word, valid when rd_vld=1
//   rd_en         in   1      read ready; pop = rd_vld & rd_en
//   rd_vld        out  1      head word valid
//   rd_udf        out  1      pulse: rd_en seen while rd_vld=0
//   data_cnt      out  AW+2   words held (RAM + read in flight + buffer)
//   almost_full   out  1      data_cnt >= c_AF_LEVEL
//   almost_empty  out  1      data_cnt <= c_AE_LEVEL
// ============================================================================
module ipml_prefetch_fifo_v2_0_sync #(
    parameter int c_DEPTH_WIDTH    = 10,
    parameter int c_DATA_WIDTH     = 32,
    parameter int c_PREFETCH_DEPTH = 2,
    parameter int c_AF_LEVEL       = 2**c_DEPTH_WIDTH - 4,
    parameter int c_AE_LEVEL       = 4,
    parameter int c_BYPASS         = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic [c_DATA_WIDTH-1:0]    wr_data,
    input  logic                       wr_en,
    output logic                       wr_vld,
    output logic                       wr_ovf,
    output logic [c_DATA_WIDTH-1:0]    rd_data,
    input  logic                       rd_en,
    output logic                       rd_vld,
    output logic                       rd_udf,
    output logic [c_DEPTH_WIDTH+1:0]   data_cnt,
    output logic                       almost_full,
    output logic                       almost_empty
);

    localparam int AW    = c_DEPTH_WIDTH;
    localparam int DW    = c_DATA_WIDTH;
    localparam int PF    = c_PREFETCH_DEPTH;
    localparam int CW    = AW + 2;
    localparam int BW    = $clog2(PF + 1);
    localparam int DEPTH = 2**AW;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [AW:0]    wr_ptr_reg;
    logic [AW:0]    rd_ptr_reg;
    logic           ready_reg;          // low only while/just after reset
    logic           inflight_reg;       // a word is in the landing stage
    logic           land_byp_reg;       // landing word came from the bypass path
    logic [DW-1:0]  ram_rd_data_reg;
    logic [DW-1:0]  byp_data_reg;
    logic [DW-1:0]  ram_mem [DEPTH];
    logic [DW-1:0]  buf_reg [PF];
    logic [BW-1:0]  buf_cnt_reg;
    logic [CW-1:0]  data_cnt_reg;
    logic           almost_full_reg;
    logic           almost_empty_reg;
    logic           wr_ovf_reg;
    logic           rd_udf_reg;

    // ------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------
    logic           ram_full;
    logic           ram_empty;
    logic           fifo_empty;
    logic           push;
    logic           pop;
    logic           byp_take;
    logic           ram_wr_en;
    logic           rd_issue;
    logic [DW-1:0]  land_data;
    logic [BW-1:0]  keep_cnt;
    logic [BW-1:0]  buf_cnt_next;
    logic [DW-1:0]  buf_next [PF];
    logic [CW-1:0]  data_cnt_next;

    assign ram_empty  = (wr_ptr_reg == rd_ptr_reg);
    assign ram_full   = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                        (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign fifo_empty = ram_empty && !inflight_reg && (buf_cnt_reg == '0);

    // Ready is derived from registered state only, so a pop in the full
    // cycle frees the slot one cycle later.
    assign wr_vld = ready_reg && !ram_full;
    assign rd_vld = (buf_cnt_reg != '0);

    assign push = wr_en && wr_vld && !flush && !rst;
    assign pop  = rd_en && rd_vld && !flush && !rst;

    // Bypass only when nothing at all is held, so word order cannot change.
    assign byp_take  = (c_BYPASS != 0) && push && fifo_empty;
    assign ram_wr_en = push && !byp_take;

    // Issue a RAM read only if the word is sure to find a buffer slot when
    // it lands: entries held + in flight - leaving this edge < depth.
    assign rd_issue = !ram_empty && !flush && !rst &&
                      ((4'(buf_cnt_reg) + 4'(inflight_reg)) < (4'(PF) + 4'(pop)));

    assign land_data = land_byp_reg ? byp_data_reg : ram_rd_data_reg;

    // Entries remaining after this edge's pop; a landing word goes right
    // behind them.
    assign keep_cnt     = buf_cnt_reg - BW'(pop);
    assign buf_cnt_next = keep_cnt + BW'(inflight_reg);

    // ------------------------------------------------------------------
    // Prefetch buffer next-state: shift toward the head on pop, then drop
    // the landing word into the first free slot.
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < PF; gi++) begin : g_buf
            logic [DW-1:0] shifted;
            if (gi < PF - 1) begin : g_shift
                assign shifted = pop ? buf_reg[gi+1] : buf_reg[gi];
            end else begin : g_last
                assign shifted = buf_reg[gi];
            end
            assign buf_next[gi] = (inflight_reg && (keep_cnt == BW'(gi))) ? land_data : shifted;
        end
    endgenerate

    always_comb begin
        data_cnt_next = data_cnt_reg;
        if (push && !pop) begin
            data_cnt_next = data_cnt_reg + CW'(1);
        end else if (pop && !push) begin
            data_cnt_next = data_cnt_reg - CW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Inferred RAM: synchronous write, registered read.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (ram_wr_en) begin
            ram_mem[wr_ptr_reg[AW-1:0]] <= wr_data;
        end
        if (rd_issue) begin
            ram_rd_data_reg <= ram_mem[rd_ptr_reg[AW-1:0]];
        end
    end

    // Bypass word parks here for one cycle, mirroring the RAM read latency
    // from the landing stage's point of view.
    always_ff @(posedge clk) begin
        if (byp_take) begin
            byp_data_reg <= wr_data;
        end
    end

    // ------------------------------------------------------------------
    // Control and output registers. rst and flush clear the same state;
    // only ready_reg distinguishes them.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            ready_reg        <= !rst;
            wr_ptr_reg       <= '0;
            rd_ptr_reg       <= '0;
            inflight_reg     <= 1'b0;
            land_byp_reg     <= 1'b0;
            buf_cnt_reg      <= '0;
            data_cnt_reg     <= '0;
            almost_full_reg  <= 1'b0;
            almost_empty_reg <= 1'b1;
            wr_ovf_reg       <= 1'b0;
            rd_udf_reg       <= 1'b0;
            for (int i = 0; i < PF; i++) begin
                buf_reg[i] <= '0;
            end
        end else begin
            ready_reg <= 1'b1;
            if (ram_wr_en) begin
                wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
            end
            if (rd_issue) begin
                rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
            end
            inflight_reg     <= rd_issue || byp_take;
            land_byp_reg     <= byp_take;
            buf_cnt_reg      <= buf_cnt_next;
            data_cnt_reg     <= data_cnt_next;
            almost_full_reg  <= (int'(data_cnt_next) >= c_AF_LEVEL);
            almost_empty_reg <= (int'(data_cnt_next) <= c_AE_LEVEL);
            wr_ovf_reg       <= wr_en && !wr_vld;
            rd_udf_reg       <= rd_en && !rd_vld;
            for (int i = 0; i < PF; i++) begin
                buf_reg[i] <= buf_next[i];
            end
        end
    end

    assign rd_data      = buf_reg[0];
    assign data_cnt     = data_cnt_reg;
    assign almost_full  = almost_full_reg;
    assign almost_empty = almost_empty_reg;
    assign wr_ovf       = wr_ovf_reg;
    assign rd_udf       = rd_udf_reg;

endmodule

// File: tb/tb_ipml_prefetch_fifo_v2_0_sync.sv
// ============================================================================
// tb_ipml_prefetch_fifo_v2_0_sync
// Four FIFO instances (PF=2, PF=3, PF=4 without bypass, PF=2 with bypass)
// share one stimulus stream. Each has its own queue model: words accepted on
// wr_en & wr_vld are appended, words taken on rd_en & rd_vld must match the
// queue head. Count, flags and pulses are predicted from the queue length.
// ============================================================================
`timescale 1ns/1ps
module tb_ipml_prefetch_fifo_v2_0_sync;

    localparam int AW        = 4;
    localparam int DW        = 8;
    localparam int N         = 4;
    localparam int AF        = 12;
    localparam int AE        = 3;
    localparam int RAM_WORDS = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst;
    logic           flush;
    logic           wr_en;
    logic           rd_en;
    logic [DW-1:0]  wr_data;
    logic [N-1:0]   wr_vld;
    logic [N-1:0]   wr_ovf;
    logic [N-1:0]   rd_vld;
    logic [N-1:0]   rd_udf;
    logic [N-1:0]   almost_full;
    logic [N-1:0]   almost_empty;
    logic [DW-1:0]  rd_data  [N];
    logic [AW+1:0]  data_cnt [N];

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_dut
            localparam int PF  = (gi == 1) ? 3 : (gi == 2) ? 4 : 2;
            localparam int BYP = (gi == 3) ? 1 : 0;
            ipml_prefetch_fifo_v2_0_sync #(
                .c_DEPTH_WIDTH    (AW),
                .c_DATA_WIDTH     (DW),
                .c_PREFETCH_DEPTH (PF),
                .c_AF_LEVEL       (AF),
                .c_AE_LEVEL       (AE),
                .c_BYPASS         (BYP)
            ) u_dut (
                .clk          (clk),
                .rst          (rst),
                .flush        (flush),
                .wr_data      (wr_data),
                .wr_en        (wr_en),
                .wr_vld       (wr_vld[gi]),
                .wr_ovf       (wr_ovf[gi]),
                .rd_data      (rd_data[gi]),
                .rd_en        (rd_en),
                .rd_vld       (rd_vld[gi]),
                .rd_udf       (rd_udf[gi]),
                .data_cnt     (data_cnt[gi]),
                .almost_full  (almost_full[gi]),
                .almost_empty (almost_empty[gi])
            );
        end
    endgenerate

    // RAM write strobe of the bypass instance, watched during the latency test.
    logic byp_watch = 1'b0;
    int   byp_ram_we_cnt = 0;
    always @(posedge clk) begin
        if (byp_watch && g_dut[3].u_dut.ram_wr_en) begin
            byp_ram_we_cnt <= byp_ram_we_cnt + 1;
        end
    end

    // ------------------------------------------------------------------
    // Reference model and checking
    // ------------------------------------------------------------------
    logic [DW-1:0] mdl_mem [N][64];
    int            mdl_wr [N];
    int            mdl_rd [N];
    int            push_total = 0;
    int            checks = 0;
    int            failures = 0;
    int            cur_dut = 0;

    function automatic int cap_of(input int i);
        return RAM_WORDS + ((i == 1) ? 3 : (i == 2) ? 4 : 2);
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s dut=%0d got=%0d expected=%0d", tag, cur_dut, obs, exp);
        end
    endtask

    // One clock: sample handshakes before the edge, advance the model by the
    // transfers that edge performs, then compare registered outputs after it.
    task automatic cycle();
        logic [N-1:0]  wv;
        logic [N-1:0]  rv;
        logic [DW-1:0] rdd [N];
        logic          rs;
        logic          fl;
        logic          we;
        logic          re;
        logic [DW-1:0] wd;
        logic          e_ovf;
        logic          e_udf;
        int            cnt;
        @(negedge clk);
        wv = wr_vld;
        rv = rd_vld;
        rs = rst;
        fl = flush;
        we = wr_en;
        re = rd_en;
        wd = wr_data;
        for (int i = 0; i < N; i++) rdd[i] = rd_data[i];
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            cur_dut = i;
            e_ovf = 1'b0;
            e_udf = 1'b0;
            if (rs || fl) begin
                mdl_rd[i] = 0;
                mdl_wr[i] = 0;
            end else begin
                if (mdl_wr[i] == mdl_rd[i]) chk("rd_vld_when_empty", int'(rv[i]), 0);
                if (rv[i]) chk("head_data", int'(rdd[i]), int'(mdl_mem[i][mdl_rd[i] % 64]));
                e_ovf = we && !wv[i];
                e_udf = re && !rv[i];
                if (re && rv[i]) mdl_rd[i]++;
                if (we && wv[i]) begin
                    mdl_mem[i][mdl_wr[i] % 64] = wd;
                    mdl_wr[i]++;
                    if (i == 0) push_total++;
                end
            end
            cnt = mdl_wr[i] - mdl_rd[i];
            chk("data_cnt", int'(data_cnt[i]), cnt);
            chk("almost_full", int'(almost_full[i]), int'(cnt >= AF));
            chk("almost_empty", int'(almost_empty[i]), int'(cnt <= AE));
            chk("wr_ovf", int'(wr_ovf[i]), int'(e_ovf));
            chk("rd_udf", int'(rd_udf[i]), int'(e_udf));
            if (rs) begin
                chk("rst_wr_vld", int'(wr_vld[i]), 0);
                chk("rst_rd_vld", int'(rd_vld[i]), 0);
                chk("rst_rd_data", int'(rd_data[i]), 0);
            end else if (cnt < RAM_WORDS) begin
                chk("wr_vld_room", int'(wr_vld[i]), 1);
            end else if (cnt == cap_of(i)) begin
                chk("wr_vld_full", int'(wr_vld[i]), 0);
            end
        end
    endtask

    initial begin
        rst     = 1'b1;
        flush   = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        wr_data = '0;
        for (int i = 0; i < N; i++) begin
            mdl_wr[i] = 0;
            mdl_rd[i] = 0;
        end

        // Reset and release
        repeat (3) cycle();
        rst = 1'b0;
        cycle();
        for (int i = 0; i < N; i++) begin
            cur_dut = i;
            chk("post_rst_wr_vld", int'(wr_vld[i]), 1);
            chk("post_rst_ae", int'(almost_empty[i]), 1);
        end
        $display("tx reset released");
        repeat (2) cycle();

        // Single-word latency, with and without bypass
        byp_watch = 1'b1;
        wr_en   = 1'b1;
        wr_data = 8'hA5;
        cycle();
        wr_en = 1'b0;
        for (int i = 0; i < N; i++) begin
            cur_dut = i;
            chk("lat_e0_vld", int'(rd_vld[i]), 0);
        end
        cycle();
        for (int i = 0; i < N; i++) begin
            cur_dut = i;
            chk("lat_e1_vld", int'(rd_vld[i]), int'(i == 3));
        end
        cur_dut = 3;
        chk("lat_e1_byp_data", int'(rd_data[3]), 8'hA5);
        cycle();
        for (int i = 0; i < N; i++) begin
            cur_dut = i;
            chk("lat_e2_vld", int'(rd_vld[i]), 1);
            chk("lat_e2_data", int'(rd_data[i]), 8'hA5);
            chk("lat_e2_cnt", int'(data_cnt[i]), 1);
        end
        byp_watch = 1'b0;
        cur_dut = 3;
        chk("byp_ram_we", byp_ram_we_cnt, 0);
        $display("tx push 0xa5 latency observed");
        rd_en = 1'b1;
        cycle();
        rd_en = 1'b0;
        cycle();

        // Fill until full with reads held off
        for (int k = 0; k < 18; k++) begin
            wr_en   = 1'b1;
            wr_data = DW'(k);
            cycle();
            $display("tx push data=%0d dut0_cnt=%0d", k, data_cnt[0]);
        end
        cur_dut = 0;
        chk("fill_wr_vld", int'(wr_vld[0]), 0);
        chk("fill_cnt", int'(data_cnt[0]), 18);
        wr_data = 8'd18;
        cycle();
        wr_en = 1'b0;
        cur_dut = 0;
        chk("fill_ovf", int'(wr_ovf[0]), 1);
        chk("fill_cnt_hold", int'(data_cnt[0]), 18);
        cycle();
        cur_dut = 0;
        chk("fill_ovf_pulse", int'(wr_ovf[0]), 0);

        // Drain with rd_en held: one word per cycle, no gaps
        rd_en = 1'b1;
        for (int k = 0; k < 18; k++) begin
            cur_dut = 0;
            chk("drain_vld", int'(rd_vld[0]), 1);
            chk("drain_data", int'(rd_data[0]), k);
            cycle();
            $display("tx pop data=%0d", k);
        end
        cur_dut = 0;
        chk("drain_empty", int'(rd_vld[0]), 0);
        cycle();
        cur_dut = 0;
        chk("drain_udf", int'(rd_udf[0]), 1);
        repeat (4) cycle();
        rd_en = 1'b0;
        cycle();
        cur_dut = 0;
        chk("drain_udf_pulse", int'(rd_udf[0]), 0);

        // Random traffic
        for (int c = 0; c < 10000; c++) begin
            wr_en   = 1'($urandom_range(0, 1));
            rd_en   = 1'($urandom_range(0, 1));
            wr_data = DW'($urandom);
            cycle();
        end
        wr_en = 1'b0;
        rd_en = 1'b0;
        cur_dut = 0;
        chk("wrap_crossings", int'((push_total / RAM_WORDS) >= 100), 1);
        $display("tx random done pushes=%0d", push_total);

        // Flush with data held and push+pop in the flush cycle
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        for (int k = 0; k < 7; k++) begin
            wr_en   = 1'b1;
            wr_data = DW'(8'h40 + k);
            cycle();
        end
        wr_en = 1'b0;
        repeat (3) cycle();
        for (int i = 0; i < N; i++) begin
            cur_dut = i;
            chk("pre_flush_cnt", int'(data_cnt[i]), 7);
        end
        flush   = 1'b1;
        wr_en   = 1'b1;
        rd_en   = 1'b1;
        wr_data = 8'h77;
        cycle();
        flush = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        for (int i = 0; i < N; i++) begin
            cur_dut = i;
            chk("flush_cnt", int'(data_cnt[i]), 0);
            chk("flush_rd_vld", int'(rd_vld[i]), 0);
            chk("flush_ae", int'(almost_empty[i]), 1);
            chk("flush_wr_vld", int'(wr_vld[i]), 1);
            chk("flush_ovf", int'(wr_ovf[i]), 0);
            chk("flush_udf", int'(rd_udf[i]), 0);
        end
        $display("tx flush with 7 words");

        // Reset in the middle of traffic
        for (int k = 0; k < 5; k++) begin
            wr_en   = 1'b1;
            rd_en   = 1'($urandom_range(0, 1));
            wr_data = DW'($urandom);
            cycle();
        end
        rst   = 1'b1;
        wr_en = 1'b1;
        rd_en = 1'b1;
        repeat (2) begin
            cycle();
            for (int i = 0; i < N; i++) begin
                cur_dut = i;
                chk("mid_rst_wr_vld", int'(wr_vld[i]), 0);
                chk("mid_rst_cnt", int'(data_cnt[i]), 0);
                chk("mid_rst_rd_vld", int'(rd_vld[i]), 0);
                chk("mid_rst_ae", int'(almost_empty[i]), 1);
            end
        end
        rst   = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        cycle();
        for (int i = 0; i < N; i++) begin
            cur_dut = i;
            chk("mid_rst_release", int'(wr_vld[i]), 1);
        end
        $display("tx reset mid-stream");

        // Short traffic after reset to confirm normal operation resumes
        for (int k = 0; k < 3; k++) begin
            wr_en   = 1'b1;
            wr_data = DW'(8'hC0 + k);
            cycle();
        end
        wr_en = 1'b0;
        rd_en = 1'b1;
        repeat (6) cycle();
        rd_en = 1'b0;
        cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
